mult_div_unit: RTL

//   Execute-stage multiply/divide unit owning the HI/LO registers. Consumes the

---
 rtl/mult_div_unit_if.sv | 14 +
 rtl/mult_div_unit.sv | 71 +++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operation request (start/MDOp/A/B) and result (busy/HI/LO) bundle
//   master: drives start, MDOp, A, B; observes busy, HI, LO
//   slave : observes start, MDOp, A, B; drives busy, HI, LO
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master(output start, MDOp, A, B, input busy, HI, LO);
    modport slave(input start, MDOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning the HI/LO registers
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   md    : slave side of mult_div_unit_if (start, MDOp, A, B in; busy, HI, LO out)
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave md
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [31:0] cnt, ph, pl, hi, lo, bd;
    logic [63:0] smul, umul, res;
    logic signed [31:0] sa, sb, sq, sr;
    logic dz, launch, is_div, done, ovf, idle_op;
    assign idle_op = md.start && state == IDLE;
    assign launch  = idle_op && md.MDOp != 3'd0 && md.MDOp < 3'd5;
    assign is_div  = md.MDOp == 3'd3 || md.MDOp == 3'd4;
    assign done    = state == RUN && cnt == 32'd1;
    // Divisor forced to 1 on divide-by-zero; the commit is suppressed anyway
    assign bd      = (md.B == 32'd0) ? 32'd1 : md.B;
    assign ovf     = md.A == 32'h8000_0000 && md.B == 32'hFFFF_FFFF;
    always_comb begin
        sa   = md.A;
        sb   = bd;
        sq   = sa / sb;
        sr   = sa % sb;
        smul = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
        umul = {32'd0, md.A} * {32'd0, md.B};
        res  = md.MDOp == 3'd1 ? smul :
               md.MDOp == 3'd2 ? umul :
               md.MDOp == 3'd3 ? (ovf ? {32'd0, 32'h8000_0000} : {sr, sq}) :
               {md.A % bd, md.A / bd};
    end
    always_comb begin
        state_n = state;
        state_n = launch ? RUN : done ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ph    <= '0;
            pl    <= '0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            if (launch) begin
                {ph, pl} <= res;
                dz       <= is_div && md.B == 32'd0;
                cnt      <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - 32'd1;
            end
            if (done && !dz) begin
                hi <= ph;
                lo <= pl;
            end
            if (idle_op && md.MDOp == 3'd5) hi <= md.A;
            if (idle_op && md.MDOp == 3'd6) lo <= md.A;
        end
    end
    assign md.busy = state == RUN;
    assign md.HI   = hi;
    assign md.LO   = lo;
endmodule
